// File: rtl/stim_sweep_gen.sv
// Stepped-sweep stimulus source: emits n_steps saturating fixed-point values, each held
// for a programmable number of cycles, with a settle strobe on the last cycle of each window.
module stim_sweep_gen #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic signed [WIDTH-1:0]     start_val,
    input  logic signed [WIDTH-1:0]     step_val,
    input  logic        [CNT_WIDTH-1:0] n_steps,
    input  logic        [CNT_WIDTH-1:0] hold,
    output logic signed [WIDTH-1:0]     stim,
    output logic                        busy,
    output logic                        sample,
    output logic        [CNT_WIDTH-1:0] idx,
    output logic                        done,
    output logic                        sat
);

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    localparam logic signed [WIDTH:0] MAX_V = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] MIN_V = {2'b11, {(WIDTH-1){1'b0}}};

    state_t                  state, state_nxt;
    logic signed [WIDTH-1:0] step_r;
    logic [CNT_WIDTH-1:0]    n_r, h_r, hold_cnt;
    logic signed [WIDTH:0]   sum;
    logic signed [WIDTH-1:0] stim_nxt;
    logic                    ovf;
    logic                    last_win, last_val, start_ok;

    assign start_ok = start && (n_steps != '0);
    assign last_win = (state == HOLD) && (hold_cnt == h_r - CNT_WIDTH'(1));
    assign last_val = (idx == n_r - CNT_WIDTH'(1));
    assign sample   = last_win;

    // One guard bit makes both overflow directions visible before clamping.
    assign sum = {stim[WIDTH-1], stim} + {step_r[WIDTH-1], step_r};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        stim_nxt = sum[WIDTH-1:0];
        ovf      = 1'b0;
        if (sum > MAX_V) begin
            stim_nxt = MAX_V[WIDTH-1:0];
            ovf      = 1'b1;
        end else if (sum < MIN_V) begin
            stim_nxt = MIN_V[WIDTH-1:0];
            ovf      = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = HOLD;
            HOLD:    if (last_win && last_val) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            stim     <= '0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat      <= 1'b0;
            step_r   <= '0;
            n_r      <= '0;
            h_r      <= CNT_WIDTH'(1);
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == HOLD);
            done  <= (state_nxt == DONE);
            if (!abort) begin
                case (state)
                    IDLE: if (start_ok) begin
                        step_r   <= step_val;
                        n_r      <= n_steps;
                        h_r      <= (hold == '0) ? CNT_WIDTH'(1) : hold;
                        stim     <= start_val;
                        idx      <= '0;
                        hold_cnt <= '0;
                        sat      <= 1'b0;
                    end
                    HOLD: if (last_win) begin
                        if (!last_val) begin
                            stim     <= stim_nxt;
                            idx      <= idx + CNT_WIDTH'(1);
                            hold_cnt <= '0;
                            sat      <= sat | ovf;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CNT_WIDTH'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stim_sweep_gen.sv
// Directed bench for stim_sweep_gen: hand-computed sweeps, saturation, abort, retrigger
// and asynchronous reset, each value checked cycle by cycle.
module tb_stim_sweep_gen;

    logic               clk = 1'b0;
    logic               rst;
    logic               start, abort;
    logic signed [15:0] start_val, step_val;
    logic        [15:0] n_steps, hold;
    logic signed [15:0] stim;
    logic               busy, sample, done, sat;
    logic        [15:0] idx;

    int checks   = 0;
    int failures = 0;

    stim_sweep_gen #(.WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_val(start_val), .step_val(step_val), .n_steps(n_steps), .hold(hold),
        .stim(stim), .busy(busy), .sample(sample), .idx(idx), .done(done), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, $signed(got), got, $signed(exp), exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs a full sweep and checks every cycle; retrig_k pulses start with a bogus
    // start_val on that cycle of the sweep (0 disables it).
    task automatic run_sweep(input logic signed [15:0] sv, input logic signed [15:0] st,
                             input logic [15:0] n, input logic [15:0] h,
                             input logic signed [15:0] e0, input logic signed [15:0] e1,
                             input logic signed [15:0] e2, input logic signed [15:0] e3,
                             input logic fsat, input int retrig_k);
        logic signed [15:0] ev[4];
        int hh;
        int nn;
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        hh = (h == 0) ? 1 : int'(h);
        nn = int'(n);
        start_val = sv; step_val = st; n_steps = n; hold = h; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= nn * hh; k++) begin
            check("sweep_stim",   32'(stim),   32'(ev[(k-1)/hh]));
            check("sweep_idx",    32'(idx),    32'((k-1)/hh));
            check("sweep_busy",   32'(busy),   32'd1);
            check("sweep_sample", 32'(sample), 32'((k % hh) == 0));
            check("sweep_done",   32'(done),   32'd0);
            if (k == 1) check("sweep_sat_cleared", 32'(sat), 32'd0);
            if (k == retrig_k) begin
                start = 1'b1;
                start_val = 16'sd999;
            end else begin
                start = 1'b0;
            end
            tick;
        end
        start = 1'b0;
        check("end_done",   32'(done),   32'd1);
        check("end_busy",   32'(busy),   32'd0);
        check("end_sample", 32'(sample), 32'd0);
        check("end_stim",   32'(stim),   32'(ev[nn-1]));
        check("end_idx",    32'(idx),    32'(nn-1));
        check("end_sat",    32'(sat),    32'(fsat));
        tick;
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        start_val = '0; step_val = '0; n_steps = '0; hold = '0;
        #3;
        check("rst_stim",   32'(stim),   32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_idx",    32'(idx),    32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_sat",    32'(sat),    32'd0);
        tick; tick;
        rst = 1'b1;
        tick;

        // Basic sweep: 100,125,150,175 held 3 cycles each.
        run_sweep(16'sd100, 16'sd25, 16'd4, 16'd3,
                  16'sd100, 16'sd125, 16'sd150, 16'sd175, 1'b0, 0);

        // Saturation at the positive rail, one cycle per value.
        run_sweep(16'sd32000, 16'sd500, 16'd3, 16'd1,
                  16'sd32000, 16'sd32500, 16'sd32767, 16'sd0, 1'b1, 0);

        // Negative values with hold=0 treated as 1; sat from previous sweep cleared.
        run_sweep(-16'sd10, -16'sd5, 16'd2, 16'd0,
                  -16'sd10, -16'sd15, 16'sd0, 16'sd0, 1'b0, 0);

        // Saturation at the negative rail.
        run_sweep(-16'sd32000, -16'sd700, 16'd3, 16'd2,
                  -16'sd32000, -16'sd32700, -16'sd32768, 16'sd0, 1'b1, 0);

        // n_steps=0: start ignored entirely.
        start_val = 16'sd7; step_val = 16'sd1; n_steps = 16'd0; hold = 16'd2; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("nsteps0_busy", 32'(busy), 32'd0);
            check("nsteps0_done", 32'(done), 32'd0);
            tick;
        end
        check("nsteps0_stim_kept", 32'(stim), 32'hFFFF8000);

        // Abort on the sample cycle of idx=2: values 0,10,20,30 hold 2.
        start_val = 16'sd0; step_val = 16'sd10; n_steps = 16'd4; hold = 16'd2; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k < 6; k++) tick;
        check("abort_pre_idx",    32'(idx),    32'd2);
        check("abort_pre_sample", 32'(sample), 32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        check("abort_sample", 32'(sample), 32'd0);
        check("abort_stim",   32'(stim),   32'd20);
        check("abort_idx",    32'(idx),    32'd2);
        tick;
        check("abort_post_done", 32'(done), 32'd0);
        check("abort_post_busy", 32'(busy), 32'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("restart_idx",  32'(idx),  32'd0);
        check("restart_stim", 32'(stim), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        tick;

        // Start pulsed at idx=1 with a new start_val must not retrigger.
        run_sweep(16'sd5, 16'sd1, 16'd3, 16'd2,
                  16'sd5, 16'sd6, 16'sd7, 16'sd0, 1'b0, 3);

        // Asynchronous reset mid-sweep takes effect before the next edge.
        run_sweep(16'sd100, 16'sd25, 16'd4, 16'd3,
                  16'sd100, 16'sd125, 16'sd150, 16'sd175, 1'b0, 0);
        start_val = 16'sd100; step_val = 16'sd25; n_steps = 16'd4; hold = 16'd3; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k < 5; k++) tick;
        check("mid_stim_before_rst", 32'(stim), 32'd125);
        #2 rst = 1'b0;
        #1;
        check("async_rst_stim", 32'(stim), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_idx",  32'(idx),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick; tick;
        check("after_rst_busy", 32'(busy), 32'd0);
        check("after_rst_done", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
